// File: rtl/vga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : vga_pkg                                              |
// | Description : Shared phase type, default 640x480@60 timing and a   |
// |               helper that sums the four phase lengths of an axis.  |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package vga_pkg;

  // Raster phases, in the order an axis walks through them.
  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_t;

  // 640x480 @ 60 Hz standard timing.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Total length of one axis (ticks per line or lines per frame).
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : vga_axis_counter                                     |
// | Description : One raster axis: a position counter plus its phase   |
// |               FSM. Exposes the next phase and a wrap strobe so the |
// |               parent can register decoded outputs aligned with cnt.|
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE_LEN = DEF_H_ACTIVE,
  parameter int FP_LEN     = DEF_H_FP,
  parameter int SYNC_LEN   = DEF_H_SYNC,
  parameter int BP_LEN     = DEF_H_BP,
  parameter int CNT_W      = $clog2(axis_total(ACTIVE_LEN, FP_LEN, SYNC_LEN, BP_LEN))
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             advance,
  output logic [CNT_W-1:0] cnt,
  output phase_t           state_nxt,
  output logic             wrap
);

  localparam int TOTAL = axis_total(ACTIVE_LEN, FP_LEN, SYNC_LEN, BP_LEN);

  // Last count of each phase; leaving it moves the FSM on.
  localparam logic [CNT_W-1:0] LAST_ACTIVE = CNT_W'(ACTIVE_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_FP     = CNT_W'(ACTIVE_LEN + FP_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_SYNC   = CNT_W'(ACTIVE_LEN + FP_LEN + SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_BP     = CNT_W'(TOTAL - 1);

  phase_t           state;
  logic [CNT_W-1:0] cnt_nxt;
  logic             at_phase_end;

  // Position and phase registers; reset lands on the first active count.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      state <= PH_ACTIVE;
    end else begin
      cnt   <= cnt_nxt;
      state <= state_nxt;
    end
  end

  // Next count, next phase and wrap strobe for the current advance.
  always_comb begin
    cnt_nxt      = cnt;
    state_nxt    = state;
    wrap         = 1'b0;
    at_phase_end = 1'b0;

    case (state)
      PH_ACTIVE: at_phase_end = (cnt == LAST_ACTIVE);
      PH_FP:     at_phase_end = (cnt == LAST_FP);
      PH_SYNC:   at_phase_end = (cnt == LAST_SYNC);
      PH_BP:     at_phase_end = (cnt == LAST_BP);
      default:   at_phase_end = 1'b0;
    endcase

    if (advance) begin
      if (cnt == LAST_BP) begin
        cnt_nxt = '0;
        wrap    = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end

      if (at_phase_end) begin
        case (state)
          PH_ACTIVE: state_nxt = PH_FP;
          PH_FP:     state_nxt = PH_SYNC;
          PH_SYNC:   state_nxt = PH_BP;
          PH_BP:     state_nxt = PH_ACTIVE;
          default:   state_nxt = PH_ACTIVE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : vga_sync_gen                                         |
// | Description : VGA raster timing generator. Horizontal axis counts  |
// |               pixel ticks, vertical axis counts line wraps; sync,  |
// |               active-video and frame-start are registered from the |
// |               next-state values so they line up with x/y.          |
// |               Optional frame counter: define VGA_SYNC_FRAME_CNT_EN |
// |               (otherwise frame_cnt is tied to zero).               |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0,
  localparam int  H_TOTAL  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int  V_TOTAL  = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int  X_W      = $clog2(H_TOTAL),
  localparam int  Y_W      = $clog2(V_TOTAL)
) (
  input  logic           clk_in,
  input  logic           reset,
  input  logic           pix_tick,
  output logic           hsync,
  output logic           vsync,
  output logic           video_on,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           frame_start,
  output logic [7:0]     frame_cnt
);

  phase_t h_state_nxt;
  phase_t v_state_nxt;
  logic   h_wrap;
  logic   v_wrap;

  vga_axis_counter #(
    .ACTIVE_LEN (H_ACTIVE),
    .FP_LEN     (H_FP),
    .SYNC_LEN   (H_SYNC),
    .BP_LEN     (H_BP),
    .CNT_W      (X_W)
  ) u_h_axis (
    .clk_in    (clk_in),
    .reset     (reset),
    .advance   (pix_tick),
    .cnt       (x),
    .state_nxt (h_state_nxt),
    .wrap      (h_wrap)
  );

  // The vertical axis steps once per completed line.
  vga_axis_counter #(
    .ACTIVE_LEN (V_ACTIVE),
    .FP_LEN     (V_FP),
    .SYNC_LEN   (V_SYNC),
    .BP_LEN     (V_BP),
    .CNT_W      (Y_W)
  ) u_v_axis (
    .clk_in    (clk_in),
    .reset     (reset),
    .advance   (h_wrap),
    .cnt       (y),
    .state_nxt (v_state_nxt),
    .wrap      (v_wrap)
  );

  // Decoded outputs only move on a tick, so video_on stays low until the
  // first tick after reset; frame_start is a single-cycle pulse.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (pix_tick) begin
        hsync    <= (h_state_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        vsync    <= (v_state_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        video_on <= (h_state_nxt == PH_ACTIVE) && (v_state_nxt == PH_ACTIVE);
      end
      frame_start <= v_wrap;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  // Frame counter steps with the same wrap that raises frame_start.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      frame_cnt_q <= 8'd0;
    end else if (v_wrap) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_vga_sync_gen                                      |
// | Description : Self-checking bench. A small-timing instance covers  |
// |               whole frames; a default-timing instance covers the   |
// |               standard 640x480 line. Expected outputs come from a  |
// |               tick-count model using plain div/mod arithmetic.     |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_vga_sync_gen;

  // Small timing: 15 ticks per line, 10 lines per frame, active-high sync.
  localparam int S_HA = 8, S_HFP = 2, S_HS = 3, S_HBP = 2;
  localparam int S_VA = 5, S_VFP = 1, S_VS = 2, S_VBP = 2;
  localparam int S_FT = 150;
  localparam int D_FT = 800 * 525;

  logic clk_in   = 1'b0;
  logic reset    = 1'b0;
  logic pix_tick = 1'b0;

  always #5 clk_in = ~clk_in;

  logic       s_hsync, s_vsync, s_von, s_fs;
  logic [3:0] s_x, s_y;
  logic [7:0] s_fc;
  logic       d_hsync, d_vsync, d_von, d_fs;
  logic [9:0] d_x, d_y;
  logic [7:0] d_fc;

  vga_sync_gen #(
    .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
    .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP),
    .SYNC_POL (1'b1)
  ) dut (
    .clk_in (clk_in), .reset (reset), .pix_tick (pix_tick),
    .hsync (s_hsync), .vsync (s_vsync), .video_on (s_von),
    .x (s_x), .y (s_y), .frame_start (s_fs), .frame_cnt (s_fc)
  );

  vga_sync_gen dut_def (
    .clk_in (clk_in), .reset (reset), .pix_tick (pix_tick),
    .hsync (d_hsync), .vsync (d_vsync), .video_on (d_von),
    .x (d_x), .y (d_y), .frame_start (d_fs), .frame_cnt (d_fc)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // n = ticks accepted since reset was released; everything follows from it.
  longint n;
  logic   fs_s_exp, fs_d_exp;

  always @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      n        <= 0;
      fs_s_exp <= 1'b0;
      fs_d_exp <= 1'b0;
    end else begin
      if (pix_tick) n <= n + 1;
      fs_s_exp <= pix_tick && (((n + 1) % S_FT) == 0);
      fs_d_exp <= pix_tick && (((n + 1) % D_FT) == 0);
    end
  end

  task automatic model(input longint tk,
                       input int ha, input int hfp, input int hs, input int hbp,
                       input int va, input int vfp, input int vs, input int vbp,
                       input logic pol,
                       output longint ex, output longint ey,
                       output logic ehs, output logic evs, output logic evon,
                       output longint efc);
    int ht, vt;
    ht  = ha + hfp + hs + hbp;
    vt  = va + vfp + vs + vbp;
    ex  = tk % ht;
    ey  = (tk / ht) % vt;
    ehs = (ex >= ha + hfp && ex < ha + hfp + hs) ? pol : ~pol;
    evs = (ey >= va + vfp && ey < va + vfp + vs) ? pol : ~pol;
    evon = (tk != 0) && (ex < ha) && (ey < va);
`ifdef VGA_SYNC_FRAME_CNT_EN
    efc = (tk / (ht * vt)) % 256;
`else
    efc = 0;
`endif
  endtask

  // ---------------- compare process ----------------
  longint ex, ey, efc;
  logic   ehs, evs, evon;
  logic   checking = 1'b0;
  int     fs_count = 0;
  logic   d_hs_prev = 1'b1, d_von_prev = 1'b0;
  int     hs_fall_x = -1, hs_rise_x = -1, von_fall_x = -1;

  always @(negedge clk_in) begin
    #1;
    if (checking) begin
      model(n, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 1'b1,
            ex, ey, ehs, evs, evon, efc);
      check("s_x", s_x, ex);
      check("s_y", s_y, ey);
      check("s_hsync", s_hsync, ehs);
      check("s_vsync", s_vsync, evs);
      check("s_video_on", s_von, evon);
      check("s_frame_start", s_fs, fs_s_exp);
      check("s_frame_cnt", s_fc, efc);

      model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
            ex, ey, ehs, evs, evon, efc);
      check("d_x", d_x, ex);
      check("d_y", d_y, ey);
      check("d_hsync", d_hsync, ehs);
      check("d_vsync", d_vsync, evs);
      check("d_video_on", d_von, evon);
      check("d_frame_start", d_fs, fs_d_exp);
      check("d_frame_cnt", d_fc, efc);

      if (hs_fall_x < 0 && d_hs_prev && !d_hsync) hs_fall_x = int'(d_x);
      if (hs_rise_x < 0 && hs_fall_x >= 0 && !d_hs_prev && d_hsync) hs_rise_x = int'(d_x);
      if (von_fall_x < 0 && d_von_prev && !d_von) von_fall_x = int'(d_x);
      d_hs_prev  = d_hsync;
      d_von_prev = d_von;

      if (!reset) fs_count = 0;
      else if (s_fs) fs_count++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    checking = 1'b1;

    // Reset held for 5 cycles, then released with no ticks.
    reset = 1'b0;
    pix_tick = 1'b0;
    repeat (5) @(negedge clk_in);
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    #2;
    check("rst_d_hsync", d_hsync, 1'b1);
    check("rst_d_vsync", d_vsync, 1'b1);
    check("rst_s_hsync", s_hsync, 1'b0);
    check("rst_s_vsync", s_vsync, 1'b0);
    check("rst_d_video_on", d_von, 1'b0);
    check("rst_s_video_on", s_von, 1'b0);
    check("rst_d_xy", {d_y, d_x}, 20'd0);
    check("rst_s_fs_fc", {s_fs, s_fc}, 9'd0);

    // Tick every 4th clock across one full default line.
    for (int i = 0; i < 820 * 4; i++) begin
      @(negedge clk_in);
      pix_tick = (i % 4 == 0);
    end
    @(negedge clk_in);
    pix_tick = 1'b0;
    #2;
    check("d_hsync_fall_x", hs_fall_x, 656);
    check("d_hsync_rise_x", hs_rise_x, 752);
    check("d_video_off_x", von_fall_x, 640);

    // Random tick density, including idle gaps and long bursts.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_in);
      pix_tick = ($urandom_range(0, 3) != 0);
    end

    // Reach mid-frame on the small instance, then reset asynchronously.
    guard = 0;
    while (!((n % S_FT) >= 40 && (n % S_FT) <= 120) && guard < 1000) begin
      @(negedge clk_in);
      pix_tick = ($urandom_range(0, 1) != 0);
      guard++;
    end
    check("reach_mid_frame", guard < 1000, 1'b1);
    @(negedge clk_in);
    pix_tick = 1'b1;
    reset = 1'b0;
    #2;
    check("async_s_xy", {s_y, s_x}, 8'd0);
    check("async_d_xy", {d_y, d_x}, 20'd0);
    check("async_s_sync", {s_hsync, s_vsync, s_von}, 3'b000);
    check("async_d_sync", {d_hsync, d_vsync, d_von}, 3'b110);
    repeat (2) @(negedge clk_in);
    pix_tick = 1'b0;
    reset = 1'b1;
    @(negedge clk_in);
    #2;
    check("release_s_xy", {s_y, s_x}, 8'd0);

    // Tick tied high for 257 small frames.
    @(negedge clk_in);
    pix_tick = 1'b1;
    repeat (257 * S_FT) @(negedge clk_in);
    pix_tick = 1'b0;
    @(negedge clk_in);
    #2;
    check("fs_pulse_count", fs_count, 257);
    check("end_s_xy", {s_y, s_x}, 8'd0);
    check("end_d_x", d_x, 150);
    check("end_d_y", d_y, 48);
`ifdef VGA_SYNC_FRAME_CNT_EN
    check("end_frame_cnt", s_fc, 8'd1);
`else
    check("end_frame_cnt", s_fc, 8'd0);
`endif

    repeat (2) @(negedge clk_in);
    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the VGA output path. It consumes the single-cycle pixel tick derived from the board clock and produces hsync, vsync, the active-video flag, pixel coordinates and a frame-start strobe for the pixel renderer. The default parameters give the 640x480 @ 60 Hz standard timing: 800 ticks per line and 525 lines per frame.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in ticks
- H_SYNC, 96, horizontal sync width in ticks
- H_BP, 48, horizontal back porch in ticks
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines
- SYNC_POL, 0, asserted level of hsync/vsync (0 means active-low)
- clk_in  input  1  system clock; all logic is on its rising edge
- reset  input  1  asynchronous, active-low reset
- pix_tick  input  1  one-clk_in-cycle pixel enable from the clock divider
- hsync  output  1  horizontal sync, registered
- vsync  output  1  vertical sync, registered
- video_on  output  1  high while (x,y) is inside the active area, registered
- x  output  $clog2(H_TOTAL)  horizontal count, 0..H_TOTAL-1
- y  output  $clog2(V_TOTAL)  vertical count, 0..V_TOTAL-1
- frame_start  output  1  one-clk_in pulse when the position wraps to (0,0)
- frame_cnt  output  8  frame counter (see Configuration)

## Operation
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - V_TOTAL is defined the same way from the vertical parameters.
- The horizontal FSM has four states, entered in this order: ACTIVE (x<H_ACTIVE), FP, SYNC, BP, then back to ACTIVE.
  - A transition happens on the tick where x reaches the last count of the current phase.
  - The vertical FSM has the same four states and advances only on the tick where x wraps.
- Counter update on a tick:
  - x increments. At H_TOTAL-1 it wraps to 0.
  - On an x wrap, y increments. At V_TOTAL-1 it wraps to 0.
  - With pix_tick low, all state and outputs hold.
- Output decode:
  - hsync = SYNC_POL when the horizontal state is SYNC, otherwise ~SYNC_POL. vsync is decoded the same way from the vertical state.
  - video_on = both states are ACTIVE.
  - All are decoded from the next-state and next-count values and registered, so they stay aligned with x/y. There is zero relative latency.
- frame_start is high for exactly one clk_in cycle: the cycle after the tick that moves (H_TOTAL-1, V_TOTAL-1) to (0,0).
- Reset values:
  - x=0, y=0, both FSMs in ACTIVE.
  - hsync=vsync=~SYNC_POL, video_on=0, frame_start=0, frame_cnt=0.
  - video_on stays 0 until the first tick. Pixel (0,0) of the first frame after reset is therefore blank; this is intended.
- Reset asserted mid-frame forces the reset values immediately, independent of clk_in. Counting restarts at (0,0) on the first tick after release.
- pix_tick held high continuously is legal: the counters advance every clk_in.

## Timing
- Latency from the pix_tick edge to the updated outputs is 1 clk_in cycle.
- The line period is exactly H_TOTAL ticks and the frame period exactly V_TOTAL*H_TOTAL ticks. No tick may be lost or duplicated.
- The vsync edges coincide with x=0 (aligned to the line start).
- For the default parameters:
  - hsync is asserted for x in 656..751.
  - vsync is asserted for y in 490..491.
  - video_on is high for x<640 and y<480.

## Configuration
- VGA_SYNC_FRAME_CNT_EN defined:
  - frame_cnt increments modulo 256 in the same cycle that frame_start pulses.
  - It resets to 0.
- Not defined:
  - frame_cnt is tied to 0.
  - The counter register is not synthesized.

## Structure
- Shared package vga_pkg holds:
  - the phase state typedef (ACTIVE, FP, SYNC, BP);
  - the default 640x480 timing constants;
  - an H_TOTAL/V_TOTAL helper.
- One sub-module, vga_axis_counter, is natural. It contains a parameterized phase counter with its FSM, an advance input, a wrap output and a state output. It is instantiated twice: horizontal, advanced by pix_tick, and vertical, advanced by the horizontal wrap.

## Test plan
- Reset held low for 5 cycles, then released with no ticks -> all outputs hold the reset values. hsync=vsync=1 with SYNC_POL=0.
- pix_tick every 4th clk_in, default parameters -> hsync falls at x=656 and rises at x=752. video_on is low from x=640.
- Run one full frame -> vsync is low exactly on y=490,491. frame_start pulses once after 420000 ticks (1,680,000 clk_in cycles).
- pix_tick tied high -> identical sequences at a 1-clock tick rate. There is no tick skip at the x wrap or the y wrap.
- Assert reset at x=300, y=200 -> outputs return to reset values asynchronously. After release, counting restarts at (0,0).
- With VGA_SYNC_FRAME_CNT_EN defined, run 257 frames -> frame_cnt wraps 255->0 and reads 1. Without the macro, frame_cnt stays 0.
